// File: rtl/piso.sv
// -----------------------------------------------------------------------------
// piso: parameterised parallel-in serial-out shift register.
//
// Captures a WIDTH-bit word on a load strobe and shifts it out one bit per
// clock. The first bit is on data_out in the cycle right after the load edge.
// valid and last frame each word for downstream logic.
//
// Parameters:
//   WIDTH     parallel word width in bits (>= 2)
//   MSB_FIRST 1: data_in[WIDTH-1] goes out first; 0: data_in[0] goes out first
//   FILL_BIT  value shifted into the vacated register position
//
// Ports:
//   load      parallel-load strobe, sampled on rising clk
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   data_in   parallel word, captured when load=1
//   data_out  serial bit
//   valid     high while data_out carries a bit of the current word
//   last      high while data_out carries the final bit of the word
// -----------------------------------------------------------------------------
module piso #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic FILL_BIT  = 1'b0
) (
  input  logic             load,
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic             data_out,
  output logic             valid,
  output logic             last
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] cnt;

  // Load wins over shifting, so a new word restarts the frame at once and a
  // held load keeps reloading the same first bit. With cnt at zero the
  // register simply holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register sees the pre-edge values of the others.
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= data_in;
      cnt <= CNT_W'(WIDTH);
    end else if (cnt != '0) begin
      if (MSB_FIRST)
        sr <= {sr[WIDTH-2:0], FILL_BIT};
      else
        sr <= {FILL_BIT, sr[WIDTH-1:1]};
      cnt <= cnt - CNT_W'(1);
    end
  end

  // All outputs decode registered state only; load and data_in never reach
  // an output without passing through a flop.
  assign data_out = MSB_FIRST ? sr[WIDTH-1] : sr[0];
  assign valid    = (cnt != '0);
  assign last     = (cnt == CNT_W'(1));

endmodule

// File: tb/tb_piso.sv
// -----------------------------------------------------------------------------
// tb_piso: directed self-checking bench for piso (WIDTH=8, MSB first,
// fill 0). Inputs change 1 time unit after the rising edge, and outputs are
// sampled at that same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_piso;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] data_in;
  logic       data_out;
  logic       valid;
  logic       last;

  int n_checks = 0;
  int n_fails  = 0;

  piso #(
    .WIDTH    (8),
    .MSB_FIRST(1'b1),
    .FILL_BIT (1'b0)
  ) dut (
    .load    (load),
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .data_out(data_out),
    .valid   (valid),
    .last    (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual,
               expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input string tag, input logic exp_bit,
                             input logic exp_valid, input logic exp_last);
    check({tag, ".data_out"}, 32'(data_out), 32'(exp_bit));
    check({tag, ".valid"},    32'(valid),    32'(exp_valid));
    check({tag, ".last"},     32'(last),     32'(exp_last));
  endtask

  // One-cycle load pulse; returns with the first bit on data_out.
  task automatic load_word(input logic [7:0] w);
    data_in = w;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  // Checks all eight bits of w (MSB first) from the current cycle on, then
  // the idle cycle that follows.
  task automatic stream(input string tag, input logic [7:0] w);
    for (int k = 0; k < 8; k++) begin
      check_cycle($sformatf("%s.bit%0d", tag, k), w[7-k], 1'b1, k == 7);
      tick();
    end
    check_cycle({tag, ".idle"}, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst     = 1'b1;
    load    = 1'b0;
    data_in = 8'hFF;

    // Reset held with load toggling: everything stays low.
    for (int i = 0; i < 3; i++) begin
      load = ~load;
      tick();
      check_cycle($sformatf("reset%0d", i), 1'b0, 1'b0, 1'b0);
    end
    rst  = 1'b0;
    load = 1'b0;
    tick();
    tick();
    check_cycle("post_reset", 1'b0, 1'b0, 1'b0);

    // Plain words: mixed, all ones, all zeros.
    load_word(8'd15);
    stream("w0f", 8'd15);
    load_word(8'd255);
    stream("wff", 8'd255);
    load_word(8'd0);
    stream("w00", 8'd0);

    // Reload after 3 bits: 1,0,1 then the full 8'h3C -> 11 valid cycles.
    load_word(8'hA5);
    for (int k = 0; k < 3; k++) begin
      check_cycle($sformatf("a5.bit%0d", k), 8'hA5 >> (7 - k), 1'b1, 1'b0);
      if (k < 2) tick();
    end
    load_word(8'h3C);
    stream("w3c", 8'h3C);

    // Load held for three edges keeps restarting the word.
    data_in = 8'h80;
    load    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_cycle($sformatf("hold%0d", i), 1'b1, 1'b1, 1'b0);
    end
    load = 1'b0;
    check_cycle("hold_release", 1'b1, 1'b1, 1'b0);
    tick();
    for (int k = 1; k < 8; k++) begin
      check_cycle($sformatf("w80.bit%0d", k), 1'b0, 1'b1, k == 7);
      tick();
    end
    check_cycle("w80.idle", 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-word, between clock edges.
    load_word(8'hFF);
    tick();
    check_cycle("pre_arst", 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_cycle("arst_immediate", 1'b0, 1'b0, 1'b0);
    data_in = 8'h81;
    load    = 1'b1;
    tick();
    check_cycle("arst_load_ignored", 1'b0, 1'b0, 1'b0);
    rst  = 1'b0;
    load = 1'b0;
    tick();
    check_cycle("arst_released", 1'b0, 1'b0, 1'b0);
    load_word(8'h81);
    stream("w81", 8'h81);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/piso.md
Name: piso

Overview:
- Parameterised parallel-in serial-out shift register.
- Captures a WIDTH-bit word on a load strobe, then shifts it out one bit per clock, MSB first by default.
- Sits between a parallel data source and a 1-bit serial link.
- Provides frame status outputs (valid, last) so downstream logic can delimit each word.

Parameters:
- WIDTH, 8, parallel word width in bits (minimum 2).
- MSB_FIRST, 1, 1 = shift out data_in[WIDTH-1] first; 0 = data_in[0] first.
- FILL_BIT, 0, value shifted into the vacated register position on each shift.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- load  input  1  parallel-load strobe, sampled on rising clk.
- data_in  input  WIDTH  parallel word, sampled when load=1.
- data_out  output  1  serial bit.
- valid  output  1  high while data_out carries a bit of the current word.
- last  output  1  high while data_out carries the final bit of the word.
- Declaration order is fixed as load, clk, rst, data_in, data_out, valid, last, for positional instantiation compatibility.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-high on rst.
- State:
  - shift register sr[WIDTH-1:0].
  - bit counter cnt, range 0..WIDTH, width clog2(WIDTH+1).
- Reset (rst=1, asynchronous):
  - sr=0, cnt=0.
  - data_out=0, valid=0, last=0.
  - Held for as long as rst=1; load is ignored.
  - Reset mid-word aborts the word immediately.
- Load (rising clk, load=1):
  - sr <= data_in, cnt <= WIDTH.
  - Load has priority over shifting.
  - Load while a word is still shifting discards the remaining bits and restarts with the new word.
  - Load held high for several cycles reloads every cycle, so data_out stays at the first bit.
- Shift (rising clk, load=0, cnt>0):
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], FILL_BIT}.
  - MSB_FIRST=0: sr <= {FILL_BIT, sr[WIDTH-1:1]}.
  - cnt <= cnt-1.
- Idle (load=0, cnt=0): sr and cnt hold.
- data_out:
  - Combinational from the register: sr[WIDTH-1] when MSB_FIRST=1, else sr[0].
  - The first bit appears in the same cycle the load edge completes, i.e. 0 cycles of latency after the load edge.
  - Bit k of the word (k=0 is the first bit) is present during cycle k after the load edge.
- After WIDTH bits have been sent, data_out = FILL_BIT (sr is all FILL_BIT) until the next load.
- valid = (cnt != 0).
- last = (cnt == 1).
- Only registered state exists; no combinational path from load or data_in to any output.

Test Plan:
- Reset: hold rst=1 for 3 cycles with load toggling -> data_out=0, valid=0, last=0 throughout. Release rst and leave load=0 -> outputs remain 0.
- Load data_in=8'd15, pulse load for 1 cycle -> data_out over 8 cycles = 0,0,0,0,1,1,1,1. valid=1 for those 8 cycles; last=1 only on the 8th. Then data_out=0, valid=0.
- Load 8'd255, 1-cycle pulse -> eight 1s, then data_out=0 and valid=0 on cycle 9.
- Load 8'd0 -> eight 0s with valid=1 for 8 cycles, last on the 8th.
- Load 8'hA5, then load 8'h3C after 3 bits have been sent:
  - bits 1,0,1 are sent, then 0,0,1,1,1,1,0,0.
  - valid stays high for 11 consecutive cycles total.
- Assert rst asynchronously mid-word (between clock edges) -> data_out, valid and last drop to 0 immediately. After release, a fresh load of 8'h81 yields 1,0,0,0,0,0,0,1.
